// File: rtl/position_tracker.sv
// Centroid tracker: acquire/track/lost FSM with outlier rejection, shift-based EMA
// smoothing, and a red box marker drawn on the pixel stream with one cycle of latency.
module position_tracker #(
  parameter int INPUT_WIDTH = 11,
  parameter int COLOR_WIDTH = 10,
  parameter int FRAME_X_MAX = 640,
  parameter int FRAME_Y_MAX = 480,
  parameter int ALPHA_SHIFT = 2,
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 8,
  parameter int JUMP_LIMIT  = 64,
  parameter int BOX_HALF    = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [INPUT_WIDTH-1:0] x_position,
  input  logic [INPUT_WIDTH-1:0] y_position,
  input  logic                   valid_position,
  input  logic [INPUT_WIDTH-1:0] vga_x,
  input  logic [INPUT_WIDTH-1:0] vga_y,
  input  logic [COLOR_WIDTH-1:0] pixel_r_in,
  input  logic [COLOR_WIDTH-1:0] pixel_g_in,
  input  logic [COLOR_WIDTH-1:0] pixel_b_in,
  output logic [COLOR_WIDTH-1:0] pixel_r_out,
  output logic [COLOR_WIDTH-1:0] pixel_g_out,
  output logic [COLOR_WIDTH-1:0] pixel_b_out,
  output logic [INPUT_WIDTH-1:0] track_x,
  output logic [INPUT_WIDTH-1:0] track_y,
  output logic                   tracking,
  output logic                   track_update
);

  localparam int DW = INPUT_WIDTH + 1;
  localparam int HW = $clog2(ACQ_FRAMES + 1);
  localparam int MW = $clog2(LOST_FRAMES + 1);

  localparam logic [INPUT_WIDTH-1:0] X_MAX = INPUT_WIDTH'(FRAME_X_MAX);
  localparam logic [INPUT_WIDTH-1:0] Y_MAX = INPUT_WIDTH'(FRAME_Y_MAX);
  localparam logic [DW-1:0]          JUMP  = DW'(JUMP_LIMIT);
  localparam logic [DW-1:0]          BOX   = DW'(BOX_HALF);
  localparam logic [HW-1:0]          ACQ   = HW'(ACQ_FRAMES);
  localparam logic [MW-1:0]          LOST  = MW'(LOST_FRAMES);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  state_t          state;
  logic [HW-1:0]   hit_cnt;
  logic [MW-1:0]   miss_cnt;

  // Magnitude of a signed (DW-bit) difference of two unsigned coordinates.
  function automatic logic [DW-1:0] abs_diff(input logic [INPUT_WIDTH-1:0] a,
                                             input logic [INPUT_WIDTH-1:0] b);
    logic [DW-1:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DW-1] ? (~d + 1'b1) : d;
  endfunction

  // filt + floor((meas - filt) / 2^ALPHA_SHIFT); always lands between filt and meas.
  function automatic logic [INPUT_WIDTH-1:0] ema(input logic [INPUT_WIDTH-1:0] filt,
                                                 input logic [INPUT_WIDTH-1:0] meas);
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] s;
    d = $signed({1'b0, meas}) - $signed({1'b0, filt});
    s = $signed({1'b0, filt}) + (d >>> ALPHA_SHIFT);
    return s[INPUT_WIDTH-1:0];
  endfunction

  logic in_range, outlier, good;
  assign in_range = (x_position < X_MAX) && (y_position < Y_MAX);
  assign outlier  = (abs_diff(x_position, track_x) > JUMP) ||
                    (abs_diff(y_position, track_y) > JUMP);
  assign good     = in_range && ((state == IDLE) || !outlier);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      track_x      <= '0;
      track_y      <= '0;
      tracking     <= 1'b0;
      track_update <= 1'b0;
    end else if (!enable) begin
      state        <= IDLE;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      track_x      <= '0;
      track_y      <= '0;
      tracking     <= 1'b0;
      track_update <= 1'b0;
    end else begin
      track_update <= 1'b0;
      if (valid_position) begin
        unique case (state)
          IDLE: if (good) begin
            track_x      <= x_position;
            track_y      <= y_position;
            hit_cnt      <= HW'(1);
            state        <= ACQUIRE;
            track_update <= 1'b1;
          end
          ACQUIRE: if (good) begin
            track_x      <= ema(track_x, x_position);
            track_y      <= ema(track_y, y_position);
            hit_cnt      <= hit_cnt + 1'b1;
            track_update <= 1'b1;
            if (hit_cnt + 1'b1 == ACQ) begin
              state    <= TRACK;
              tracking <= 1'b1;
              miss_cnt <= '0;
            end
          end else begin
            state   <= IDLE;
            hit_cnt <= '0;
          end
          TRACK: if (good) begin
            track_x      <= ema(track_x, x_position);
            track_y      <= ema(track_y, y_position);
            miss_cnt     <= '0;
            track_update <= 1'b1;
          end else begin
            miss_cnt <= miss_cnt + 1'b1;
            if (miss_cnt + 1'b1 == LOST) begin
              state    <= IDLE;
              tracking <= 1'b0;
              hit_cnt  <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Signed distances make a partly off-screen box clip rather than wrap.
  logic [DW-1:0] adx, ady;
  logic          on_box, marker;
  assign adx    = abs_diff(vga_x, track_x);
  assign ady    = abs_diff(vga_y, track_y);
  assign on_box = ((adx == BOX) && (ady <= BOX)) || ((ady == BOX) && (adx <= BOX));
  assign marker = enable && tracking && on_box;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pixel_r_out <= '0;
      pixel_g_out <= '0;
      pixel_b_out <= '0;
    end else begin
      pixel_r_out <= marker ? '1 : pixel_r_in;
      pixel_g_out <= marker ? '0 : pixel_g_in;
      pixel_b_out <= marker ? '0 : pixel_b_in;
    end
  end

endmodule

// File: tb/tb_position_tracker.sv
// Scoreboard bench for position_tracker: stimulus pushes expected track updates and
// pixels into queues; monitors pop and compare when the DUT presents them.
module tb_position_tracker;

  logic        clk = 1'b0;
  logic        aresetn, enable, valid_position;
  logic [10:0] x_position, y_position, vga_x, vga_y;
  logic [9:0]  pixel_r_in, pixel_g_in, pixel_b_in;
  logic [9:0]  pixel_r_out, pixel_g_out, pixel_b_out;
  logic [10:0] track_x, track_y;
  logic        tracking, track_update;

  position_tracker dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .x_position(x_position), .y_position(y_position), .valid_position(valid_position),
    .vga_x(vga_x), .vga_y(vga_y),
    .pixel_r_in(pixel_r_in), .pixel_g_in(pixel_g_in), .pixel_b_in(pixel_b_in),
    .pixel_r_out(pixel_r_out), .pixel_g_out(pixel_g_out), .pixel_b_out(pixel_b_out),
    .track_x(track_x), .track_y(track_y), .tracking(tracking), .track_update(track_update)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int t; } trk_t;
  typedef struct { int r; int g; int b; } pix_t;

  trk_t trk_q[$];
  pix_t pix_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic pix_chk = 1'b0;
  logic pix_pend = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Track monitor: every track_update pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (aresetn && track_update) begin
      if (trk_q.size() == 0) begin
        check("unexpected_track_update", 1, 0);
      end else begin
        trk_t e;
        e = trk_q.pop_front();
        check("track_x", int'(track_x), e.x);
        check("track_y", int'(track_y), e.y);
        check("tracking_at_update", int'(tracking), e.t);
      end
    end
  end

  // Pixel monitor: output one cycle after a marked input cycle.
  always @(posedge clk) pix_pend <= pix_chk;

  always @(negedge clk) begin
    if (pix_pend) begin
      if (pix_q.size() == 0) begin
        check("pixel_queue_underflow", 1, 0);
      end else begin
        pix_t e;
        e = pix_q.pop_front();
        check("pixel_r", int'(pixel_r_out), e.r);
        check("pixel_g", int'(pixel_g_out), e.g);
        check("pixel_b", int'(pixel_b_out), e.b);
      end
    end
  end

  task automatic expect_trk(input int x, input int y, input int t);
    trk_q.push_back('{x, y, t});
  endtask

  task automatic meas(input int x, input int y);
    @(posedge clk); #1;
    x_position     = 11'(x);
    y_position     = 11'(y);
    valid_position = 1'b1;
    @(posedge clk); #1;
    valid_position = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pix(input int vx, input int vy, input int r, input int g, input int b,
                     input int er, input int eg, input int eb);
    @(posedge clk); #1;
    vga_x      = 11'(vx);
    vga_y      = 11'(vy);
    pixel_r_in = 10'(r);
    pixel_g_in = 10'(g);
    pixel_b_in = 10'(b);
    pix_chk    = 1'b1;
    pix_q.push_back('{er, eg, eb});
    @(posedge clk); #1;
    pix_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0; enable = 1'b1; valid_position = 1'b0;
    x_position = '0; y_position = '0; vga_x = '0; vga_y = '0;
    pixel_r_in = 10'h155; pixel_g_in = 10'h0AA; pixel_b_in = 10'h123;
    #23;
    check("reset_track_x", int'(track_x), 0);
    check("reset_track_y", int'(track_y), 0);
    check("reset_tracking", int'(tracking), 0);
    check("reset_track_update", int'(track_update), 0);
    check("reset_pixel_r", int'(pixel_r_out), 0);
    @(negedge clk); aresetn = 1'b1;

    // Out-of-range x in IDLE is ignored.
    meas(640, 10);
    check("idle_oor_tracking", int'(tracking), 0);
    check("idle_oor_track_x", int'(track_x), 0);

    // Acquire at (100,100).
    expect_trk(100, 100, 0); meas(100, 100);
    expect_trk(100, 100, 0); meas(100, 100);
    check("acq_not_yet_tracking", int'(tracking), 0);
    expect_trk(100, 100, 1); meas(100, 100);
    check("acq_tracking", int'(tracking), 1);

    // Marker around (100,100).
    pix(92, 100, 'h155, 'h0AA, 'h123, 'h3FF, 0, 0);
    pix(100, 100, 'h155, 'h0AA, 'h123, 'h155, 'h0AA, 'h123);
    pix(109, 100, 'h155, 'h0AA, 'h123, 'h155, 'h0AA, 'h123);
    pix(108, 105, 'h011, 'h022, 'h033, 'h3FF, 0, 0);
    pix(100, 108, 'h011, 'h022, 'h033, 'h3FF, 0, 0);
    pix(108, 109, 'h011, 'h022, 'h033, 'h011, 'h022, 'h033);

    // Seven outliers then a good measurement keeps the track.
    for (int i = 0; i < 7; i++) meas(300, 300);
    check("seven_miss_tracking", int'(tracking), 1);
    expect_trk(100, 100, 1); meas(100, 100);

    // Eight outliers drop the track; filtered position holds.
    for (int i = 0; i < 7; i++) meas(300, 300);
    check("miss7_tracking", int'(tracking), 1);
    meas(300, 300);
    check("lost_tracking", int'(tracking), 0);
    check("lost_hold_x", int'(track_x), 100);
    check("lost_hold_y", int'(track_y), 100);

    // Re-acquire, then EMA and the jump-limit boundary.
    expect_trk(100, 100, 0); meas(100, 100);
    expect_trk(100, 100, 0); meas(100, 100);
    expect_trk(100, 100, 1); meas(100, 100);
    expect_trk(110, 99, 1);  meas(140, 96);
    expect_trk(126, 99, 1);  meas(174, 99);
    meas(61, 99);
    check("outlier65_tracking", int'(tracking), 1);
    check("outlier65_hold_x", int'(track_x), 126);

    // enable low with a simultaneous measurement and an on-box pixel.
    @(posedge clk); #1;
    enable = 1'b0; valid_position = 1'b1; x_position = 11'd126; y_position = 11'd99;
    vga_x = 11'd118; vga_y = 11'd99;
    pixel_r_in = 10'h0F0; pixel_g_in = 10'h00F; pixel_b_in = 10'h1E1;
    pix_chk = 1'b1; pix_q.push_back('{'h0F0, 'h00F, 'h1E1});
    @(posedge clk); #1;
    enable = 1'b1; valid_position = 1'b0; pix_chk = 1'b0;
    check("disable_tracking", int'(tracking), 0);
    check("disable_track_x", int'(track_x), 0);
    check("disable_track_y", int'(track_y), 0);
    pix(118, 99, 'h0F0, 'h00F, 'h1E1, 'h0F0, 'h00F, 'h1E1);

    // Back in IDLE: the next in-range measurement loads directly.
    expect_trk(200, 200, 0); meas(200, 200);

    repeat (4) @(posedge clk); #1;
    check("track_queue_drained", trk_q.size(), 0);
    check("pixel_queue_drained", pix_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/position_tracker.md
Name: position_tracker

Overview:
- Downstream consumer of the object-centroid stage.
- Takes the per-frame centroid pulse (x_position, y_position, valid_position) and runs an acquire/track/lost state machine with outlier rejection.
- Smooths the centroid with a shift-based exponential moving average.
- Draws a red box marker around the tracked position on the outgoing VGA pixel stream, with one cycle of pipeline latency.

Parameters:
- INPUT_WIDTH, 11, width of coordinate buses.
- COLOR_WIDTH, 10, width of each colour channel.
- FRAME_X_MAX, 640, horizontal frame size; valid x range 0..FRAME_X_MAX-1.
- FRAME_Y_MAX, 480, vertical frame size; valid y range 0..FRAME_Y_MAX-1.
- ALPHA_SHIFT, 2, EMA weight is 1/2^ALPHA_SHIFT.
- ACQ_FRAMES, 3, consecutive good measurements needed to enter TRACK.
- LOST_FRAMES, 8, consecutive bad measurements in TRACK that drop the track.
- JUMP_LIMIT, 64, maximum per-axis |measurement - filtered| accepted as good.
- BOX_HALF, 8, half-size of the drawn marker box in pixels.

Ports:
- clk  in  1  pixel clock.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  synchronous clear when low.
- x_position  in  INPUT_WIDTH  measured centroid x.
- y_position  in  INPUT_WIDTH  measured centroid y.
- valid_position  in  1  one-cycle pulse; measurement is valid this cycle.
- vga_x  in  INPUT_WIDTH  current pixel x.
- vga_y  in  INPUT_WIDTH  current pixel y.
- pixel_r_in, pixel_g_in, pixel_b_in  in  COLOR_WIDTH each  video in.
- pixel_r_out, pixel_g_out, pixel_b_out  out  COLOR_WIDTH each  video out, 1-cycle latency.
- track_x  out  INPUT_WIDTH  filtered x.
- track_y  out  INPUT_WIDTH  filtered y.
- tracking  out  1  high while in TRACK.
- track_update  out  1  one-cycle pulse when track_x/track_y change.

Behaviour:
- Reset: aresetn is asynchronous, active-low; clock is clk. On reset, all outputs are 0, the state is IDLE, and hit_cnt, miss_cnt and the filtered registers are 0.
- enable low: same clear as reset, applied synchronously. Video still passes through, delayed 1 cycle, with no marker.
- Measurement classification, on the valid_position cycle only:
  - in_range = x < FRAME_X_MAX and y < FRAME_Y_MAX.
  - outlier = |x - track_x| > JUMP_LIMIT or |y - track_y| > JUMP_LIMIT. Differences are computed signed at INPUT_WIDTH+1 bits.
  - good = in_range and not outlier. In IDLE, good = in_range.
- IDLE:
  - On valid and in_range: load track <= measurement, hit_cnt <= 1, go to ACQUIRE, pulse track_update.
- ACQUIRE:
  - On valid and good: apply EMA, hit_cnt++. If hit_cnt+1 == ACQ_FRAMES, go to TRACK and set miss_cnt <= 0.
  - On valid and not good: go to IDLE and set hit_cnt <= 0; the track registers hold their value.
- TRACK:
  - On valid and good: apply EMA, miss_cnt <= 0.
  - On valid and not good: hold the track, miss_cnt++. If miss_cnt+1 == LOST_FRAMES, go to IDLE and drop tracking.
- Cycles without valid_position change no state.
- EMA, per axis:
  - d = meas - filt, signed at INPUT_WIDTH+1 bits.
  - filt <= filt + (d >>> ALPHA_SHIFT), arithmetic shift, which floors.
  - The result always lies between filt and meas, so no overflow is possible. It is truncated to INPUT_WIDTH bits.
- track_update pulses one cycle after any valid cycle that loads or updates the filter.
- Marker:
  - Registered stage; the output pixel at cycle n+1 corresponds to the inputs at cycle n.
  - Marker applies when tracking = 1 and the pixel lies on the box outline:
    - (|vga_x - track_x| == BOX_HALF and |vga_y - track_y| <= BOX_HALF), or
    - (|vga_y - track_y| == BOX_HALF and |vga_x - track_x| <= BOX_HALF).
  - Marker pixel is r = all ones, g = 0, b = 0; otherwise the input pixel is passed through.
  - Differences are signed, so a box that is partly off-screen is clipped naturally with no wrap-around.
- Simultaneous events: valid_position together with enable low means enable wins and the measurement is discarded. Reset mid-frame clears immediately.

Test Plan:
- Reset, then three valid pulses at (100,100) -> states IDLE→ACQUIRE→ACQUIRE→TRACK; tracking = 1 after the third pulse; track = (100,100).
- In TRACK at (100,100), measurement (140,96) -> track = (110,99); track_update pulses once; miss_cnt = 0.
- In TRACK, 8 consecutive measurements at (300,300) (outliers) -> track holds (100,100); tracking drops after the 8th. With 7 outliers then one good measurement, tracking stays 1.
- Measurement (640,10) in IDLE -> ignored; state remains IDLE; no track_update.
- In TRACK at (100,100): pixel (92,100) -> output r = 0x3FF, g = b = 0 one cycle later. Pixel (100,100) -> passthrough. Pixel (109,100) -> passthrough.
- enable low for one cycle during TRACK -> tracking = 0, track = (0,0), video passthrough continues. A valid pulse arriving in the same cycle is ignored.
